// File: rtl/and_dp_arbiter.sv
// rtl/and_dp_arbiter.sv - Round-robin arbiter sharing one fixed-latency AND datapath (optional ARB_FIXED_PRIO_EN)
module and_dp_arbiter #(
  parameter int N      = 2,
  parameter int DW     = 1,
  parameter int DP_LAT = 1,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   a_in,
  input  logic [N*DW-1:0]   b_in,
  output logic [N-1:0]      gnt,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DW-1:0]     rsp_data,
  output logic              busy,
  output logic [DW-1:0]     dp_in1,
  output logic [DW-1:0]     dp_in2,
  input  logic [DW-1:0]     dp_out
);

  localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-numbered active request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0]   rr_ptr;

  // Round-robin: scan upward from rr_ptr, wrapping, first active request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!win_found && req[ID_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(j);
      end
    end
  end

  // Pointer moves just past the winner on each grant; held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == S_IDLE && win_found) begin
      if (win_idx == ID_W'(N - 1)) rr_ptr <= '0;
      else                         rr_ptr <= win_idx + 1'b1;
    end
  end
`endif

  // Transaction FSM: grant and launch operands, wait out datapath latency, respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      dp_in1    <= '0;
      dp_in2    <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt    <= N'(1) << win_idx;
            dp_in1 <= a_in[int'(win_idx)*DW +: DW];
            dp_in2 <= b_in[int'(win_idx)*DW +: DW];
            rsp_id <= win_idx;
            cnt    <= CNT_W'(DP_LAT - 1);
            busy   <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= dp_out;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_dp_arbiter.sv
// tb/tb_and_dp_arbiter.sv - Directed self-checking bench for and_dp_arbiter
module tb_and_dp_arbiter;

  logic        clk = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Main instance: N=4, DW=4, DP_LAT=1
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_data;
  logic        busy;
  logic [3:0]  dp_in1, dp_in2, dp_out;

  // Second instance: N=4, DW=4, DP_LAT=3
  logic        rst3_n;
  logic [3:0]  req3;
  logic [15:0] a3, b3;
  logic [3:0]  gnt3;
  logic        rsp_valid3;
  logic [1:0]  rsp_id3;
  logic [3:0]  rsp_data3;
  logic        busy3;
  logic [3:0]  dp3_in1, dp3_in2, dp3_out;
  logic [3:0]  dp3_s1, dp3_s2;

  always #5 clk = ~clk;

  and_dp_arbiter #(.N(4), .DW(4), .DP_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_out(dp_out)
  );

  and_dp_arbiter #(.N(4), .DW(4), .DP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .a_in(a3), .b_in(b3),
    .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .busy(busy3), .dp_in1(dp3_in1), .dp_in2(dp3_in2), .dp_out(dp3_out)
  );

  // Datapath models: operand registers inside the arbiter count as the first stage.
  assign dp_out = dp_in1 & dp_in2;
  always @(posedge clk) begin
    dp3_s1 <= dp3_in1 & dp3_in2;
    dp3_s2 <= dp3_s1;
  end
  assign dp3_out = dp3_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    rst3_n = 1'b0; req3 = '0; a3 = '0; b3 = '0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if ({rsp_id, rsp_data, dp_in1, dp_in2} !== 14'd0) begin errors++;
      $display("FAIL rst_regs got id=%0d data=%h in1=%h in2=%h exp=all 0", rsp_id, rsp_data, dp_in1, dp_in2); end
  endtask

  task automatic test_single();
    rst_n = 1'b1;
    req = 4'b0100; a_in = 16'h0F00; b_in = 16'h0500;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
    checks++; if (dp_in1 !== 4'hF || dp_in2 !== 4'h5) begin errors++;
      $display("FAIL single_operands got=%h/%h exp=f/5", dp_in1, dp_in2); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 4'h5) begin errors++;
      $display("FAIL single_rsp got v=%b id=%0d d=%h exp v=1 id=2 d=5", rsp_valid, rsp_id, rsp_data); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL single_idle got busy=%b v=%b exp 0/0", busy, rsp_valid); end
    tick();
    checks++; if (dp_in1 !== 4'hF || dp_in2 !== 4'h5 || rsp_data !== 4'h5) begin errors++;
      $display("FAIL single_hold got in1=%h in2=%h d=%h exp f/5/5", dp_in1, dp_in2, rsp_data); end
  endtask

  // Held request pattern after a fresh reset; exp_ids packs the expected winner of grant k in bits [2k+:2].
  task automatic test_held_requests(input logic [3:0] pat, input logic [7:0] exp_ids);
    logic [1:0] id;
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1; req = pat; a_in = 16'hFFFF; b_in = 16'h3210;
    for (int k = 0; k < 4; k++) begin
      id = exp_ids[2*k +: 2];
      tick();
      checks++; if (gnt !== (4'b0001 << id)) begin errors++;
        $display("FAIL held_%b_gnt%0d got=%b exp=%b", pat, k, gnt, 4'b0001 << id); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== id || rsp_data !== {2'b00, id}) begin errors++;
        $display("FAIL held_%b_rsp%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%0d", pat, k, rsp_valid, rsp_id, rsp_data, id, id); end
      tick();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++;
        $display("FAIL held_%b_gap%0d got gnt=%b busy=%b exp 0000/0", pat, k, gnt, busy); end
    end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++;
      $display("FAIL held_%b_stop got gnt=%b busy=%b exp 0000/0", pat, gnt, busy); end
  endtask

  task automatic test_queued_request();
    req = 4'b0001; a_in = 16'h00F3; b_in = 16'h0016;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL queued_first_gnt got=%b exp=0001", gnt); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'h2) begin errors++;
      $display("FAIL queued_first_rsp got gnt=%b v=%b id=%0d d=%h exp 0000/1/0/2", gnt, rsp_valid, rsp_id, rsp_data); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL queued_early_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL queued_second_gnt got=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'h1) begin errors++;
      $display("FAIL queued_second_rsp got v=%b id=%0d d=%h exp 1/1/1", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_reset_abort();
    req = 4'b0100; a_in = 16'h0700; b_in = 16'h0700;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_gnt got=%b exp=0100", gnt); end
    rst_n = 1'b0; req = 4'b0000;
    tick();
    checks++; if ({gnt, rsp_valid, busy, rsp_id, rsp_data, dp_in1, dp_in2} !== 20'd0) begin errors++;
      $display("FAIL abort_outputs got gnt=%b v=%b busy=%b id=%0d d=%h in1=%h in2=%h exp all 0",
               gnt, rsp_valid, busy, rsp_id, rsp_data, dp_in1, dp_in2); end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp%0d got=%b exp=0", c, rsp_valid); end
    end
    req = 4'b1010; a_in = 16'hFFFF; b_in = 16'hC090;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_rr_restart got=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 4'h9) begin errors++;
      $display("FAIL abort_next_rsp got v=%b id=%0d d=%h exp 1/1/9", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_long_latency();
    rst3_n = 1'b1; req3 = 4'b0001; a3 = 16'h000C; b3 = 16'h000A;
    tick();
    checks++; if (gnt3 !== 4'b0001 || busy3 !== 1'b1) begin errors++;
      $display("FAIL lat3_gnt got gnt=%b busy=%b exp 0001/1", gnt3, busy3); end
    req3 = 4'b0000;
    for (int c = 2; c <= 3; c++) begin
      tick();
      checks++; if (busy3 !== 1'b1 || rsp_valid3 !== 1'b0 || gnt3 !== 4'b0000) begin errors++;
        $display("FAIL lat3_wait_t%0d got busy=%b v=%b gnt=%b exp 1/0/0000", c, busy3, rsp_valid3, gnt3); end
    end
    tick();
    checks++; if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd0 || rsp_data3 !== 4'h8 || busy3 !== 1'b1) begin errors++;
      $display("FAIL lat3_rsp got v=%b id=%0d d=%h busy=%b exp 1/0/8/1", rsp_valid3, rsp_id3, rsp_data3, busy3); end
    tick();
    checks++; if (busy3 !== 1'b0 || rsp_valid3 !== 1'b0) begin errors++;
      $display("FAIL lat3_idle got busy=%b v=%b exp 0/0", busy3, rsp_valid3); end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef ARB_FIXED_PRIO_EN
    test_held_requests(4'b1111, 8'h00);
    test_held_requests(4'b1011, 8'h00);
`else
    test_held_requests(4'b1111, 8'hE4);
    test_held_requests(4'b1011, 8'h34);
`endif
    test_queued_request();
    test_reset_abort();
    test_long_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
